// File: rtl/canbus_rx.sv
// canbus_rx: CAN 2.0A classic-frame receiver with bit-time recovery, destuffing, CRC-15 and form checks.
// Define CANBUS_RX_ACK_EN to build the ACK-slot drive; without it ack_tx is tied recessive.
module canbus_rx #(
    parameter int DIVIDER   = 53,
    parameter int IDLE_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        ack_tx,
    output logic [10:0] rx_arib,
    output logic        rx_rtr,
    output logic [3:0]  rx_dlc,
    output logic [31:0] outdata,
    output logic        valid,
    output logic        error,
    output logic [1:0]  err_code,
    output logic        busy
);
    localparam int CW = $clog2(DIVIDER + 1);
    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam logic [CW-1:0] DIV_C  = CW'(DIVIDER);
    localparam logic [CW-1:0] HALF_C = CW'(DIVIDER / 2);

    typedef enum logic [2:0] {
        WAIT_IDLE, IDLE, SOF, RECV, CRCDEL, ACKSLOT, ACKDEL
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rxs_q, rxs_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [2:0]    run_q, run_d;
    logic          last_q, last_d;
    logic [6:0]    fcnt_q, fcnt_d;
    logic [14:0]   crc_q, crc_d;
    logic          crc_ok_q, crc_ok_d;
    logic [64:0]   sr_q, sr_d;
    logic          busy_q, busy_d, valid_q, valid_d, error_q, error_d;
    logic [1:0]    code_q, code_d, err_v;
    logic [10:0]   arib_q, arib_d;
    logic          rtr_q, rtr_d;
    logic [3:0]    dlc_q, dlc_d;
    logic [31:0]   data_q, data_d;
    logic          fall, smp;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic fb;
        fb = b ^ c[14];
        crc_step = {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    assign fall = rxs_prev_q & ~rxs_q;
    assign smp  = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idle_d   = idle_q;
        run_d    = run_q;
        last_d   = last_q;
        fcnt_d   = fcnt_q;
        crc_d    = crc_q;
        crc_ok_d = crc_ok_q;
        sr_d     = sr_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        code_d   = code_q;
        arib_d   = arib_q;
        rtr_d    = rtr_q;
        dlc_d    = dlc_q;
        data_d   = data_q;
        err_v    = 2'd0;
        case (state_q)
            WAIT_IDLE: begin
                if (!rxs_q) begin
                    idle_d = '0;
                    cnt_d  = DIV_C;
                end else if (smp) begin
                    cnt_d = DIV_C;
                    if (idle_q == IW'(IDLE_BITS - 1)) begin
                        idle_d  = '0;
                        state_d = IDLE;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            IDLE: begin
                if (fall) begin
                    cnt_d   = HALF_C;
                    state_d = SOF;
                end
            end
            default: begin
                // Hard resync on every recessive-to-dominant edge while in a frame.
                if (fall)     cnt_d = HALF_C;
                else if (smp) cnt_d = DIV_C;
                else          cnt_d = cnt_q - CW'(1);
                if (smp) begin
                    case (state_q)
                        SOF: begin
                            if (!rxs_q) begin
                                busy_d  = 1'b1;
                                crc_d   = '0;
                                fcnt_d  = '0;
                                run_d   = 3'd1;
                                last_d  = 1'b0;
                                state_d = RECV;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                        RECV: begin
                            if (run_q == 3'd5) begin
                                if (rxs_q == last_q) begin
                                    err_v = 2'd1;
                                end else begin
                                    last_d = rxs_q;
                                    run_d  = 3'd1;
                                    if (fcnt_q == 7'd65) state_d = CRCDEL;
                                end
                            end else begin
                                run_d  = (rxs_q == last_q) ? run_q + 3'd1 : 3'd1;
                                last_d = rxs_q;
                                sr_d   = {sr_q[63:0], rxs_q};
                                fcnt_d = fcnt_q + 7'd1;
                                if (fcnt_q < 7'd50) crc_d = crc_step(crc_q, rxs_q);
                                if ((fcnt_q == 7'd12 || fcnt_q == 7'd13) && rxs_q) begin
                                    err_v = 2'd3;
                                end else if (fcnt_q == 7'd64) begin
                                    crc_ok_d = (crc_q == {sr_q[13:0], rxs_q});
                                    // A stuff bit may still follow the last CRC bit.
                                    if (run_d != 3'd5) state_d = CRCDEL;
                                end
                            end
                        end
                        CRCDEL: begin
                            if (!rxs_q) err_v = 2'd3;
                            else        state_d = ACKSLOT;
                        end
                        ACKSLOT: state_d = ACKDEL;
                        ACKDEL: begin
                            if (!crc_ok_q) begin
                                err_v = 2'd2;
                            end else if (!rxs_q) begin
                                err_v = 2'd3;
                            end else begin
                                arib_d  = sr_q[64:54];
                                rtr_d   = sr_q[53];
                                dlc_d   = sr_q[50:47];
                                data_d  = sr_q[46:15];
                                valid_d = 1'b1;
                                busy_d  = 1'b0;
                                idle_d  = '0;
                                cnt_d   = DIV_C;
                                state_d = WAIT_IDLE;
                            end
                        end
                        default: state_d = WAIT_IDLE;
                    endcase
                end
            end
        endcase
        if (err_v != 2'd0) begin
            error_d = 1'b1;
            code_d  = err_v;
            busy_d  = 1'b0;
            idle_d  = '0;
            cnt_d   = DIV_C;
            state_d = WAIT_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_IDLE;
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            cnt_q      <= DIV_C;
            idle_q     <= '0;
            run_q      <= '0;
            last_q     <= 1'b0;
            fcnt_q     <= '0;
            crc_ok_q   <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            code_q     <= '0;
            arib_q     <= '0;
            rtr_q      <= 1'b0;
            dlc_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            run_q      <= run_d;
            last_q     <= last_d;
            fcnt_q     <= fcnt_d;
            crc_ok_q   <= crc_ok_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            code_q     <= code_d;
            arib_q     <= arib_d;
            rtr_q      <= rtr_d;
            dlc_q      <= dlc_d;
            data_q     <= data_d;
        end
    end

    // CRC accumulator and field shifter are cleared/overwritten by every frame.
    always_ff @(posedge clk) begin
        crc_q <= crc_d;
        sr_q  <= sr_d;
    end

`ifdef CANBUS_RX_ACK_EN
    logic ack_q, ack_d;

    always_comb begin
        ack_d = ack_q;
        if (smp && state_q == CRCDEL && rxs_q && crc_ok_q)
            ack_d = 1'b0;
        else if ((smp && state_q == ACKSLOT) || err_v != 2'd0)
            ack_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ack_q <= 1'b1;
        else     ack_q <= ack_d;
    end

    assign ack_tx = ack_q;
`else
    assign ack_tx = 1'b1;
`endif

    assign rx_arib  = arib_q;
    assign rx_rtr   = rtr_q;
    assign rx_dlc   = dlc_q;
    assign outdata  = data_q;
    assign valid    = valid_q;
    assign error    = error_q;
    assign err_code = code_q;
    assign busy     = busy_q;
endmodule
